// File: rtl/mole_spawner_if.sv
// Bundles the game-side signals of the whack-a-mole round controller.
// The player/rng side drives inputs through master; the controller uses slave.
interface mole_spawner_if #(
    parameter int NUM_LEDS = 18
);
    logic                enable;
    logic                score_clr;
    logic [NUM_LEDS-1:0] random_value;
    logic [NUM_LEDS-1:0] switches;
    logic                change;
    logic [NUM_LEDS-1:0] leds;
    logic                hit_pulse;
    logic                wrong_pulse;
    logic                escape_pulse;
    logic [7:0]          score;
    logic [7:0]          misses;

    modport master (
        output enable, score_clr, random_value, switches,
        input  change, leds, hit_pulse, wrong_pulse, escape_pulse, score, misses
    );

    modport slave (
        input  enable, score_clr, random_value, switches,
        output change, leds, hit_pulse, wrong_pulse, escape_pulse, score, misses
    );
endinterface

// File: rtl/mole_spawner.sv
// Whack-a-mole round controller: requests a random value, shows a capped mole mask,
// scores switch rises against lit LEDs and counts escaped moles.
module mole_spawner #(
    parameter int NUM_LEDS  = 18,
    parameter int MAX_MOLES = 3,
    parameter int UP_TICKS  = 50_000_000,
    parameter int GAP_TICKS = 10_000_000,
    parameter int TW        = 26
) (
    input  logic           clk,
    input  logic           reset,
    mole_spawner_if.slave  bus
);
    localparam int CW = $clog2(NUM_LEDS + 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_LOAD,
        ST_SHOW,
        ST_GAP
    } state_t;

    state_t              state_reg;
    logic [TW-1:0]       timer_reg;
    logic [NUM_LEDS-1:0] leds_reg;
    logic [NUM_LEDS-1:0] sw_q_reg;
    logic                change_reg;
    logic                hit_reg;
    logic                wrong_reg;
    logic                escape_reg;
    logic [7:0]          score_reg;
    logic [7:0]          misses_reg;

    logic [NUM_LEDS-1:0] rise;
    logic [NUM_LEDS-1:0] hits;
    logic [NUM_LEDS-1:0] remain;
    logic [NUM_LEDS-1:0] capped;
    logic [CW-1:0]       taken;

    function automatic logic [CW-1:0] popcount(input logic [NUM_LEDS-1:0] v);
        logic [CW-1:0] n;
        n = '0;
        for (int i = 0; i < NUM_LEDS; i++) begin
            n = n + CW'(v[i]);
        end
        return n;
    endfunction

    function automatic logic [7:0] sat_add(input logic [7:0] a, input logic [CW-1:0] b);
        logic [8:0] s;
        s = {1'b0, a} + 9'(b);
        return s[8] ? 8'hFF : s[7:0];
    endfunction

    assign rise   = bus.switches & ~sw_q_reg;
    assign hits   = rise & leds_reg;
    assign remain = leds_reg & ~hits;

    // Keep the lowest MAX_MOLES set bits; an empty draw still lights LED 0.
    always_comb begin
        capped = '0;
        taken  = '0;
        for (int i = 0; i < NUM_LEDS; i++) begin
            if (bus.random_value[i] && (taken < CW'(MAX_MOLES))) begin
                capped[i] = 1'b1;
                taken     = taken + CW'(1);
            end
        end
        if (capped == '0) begin
            capped = NUM_LEDS'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg  <= ST_IDLE;
            timer_reg  <= '0;
            leds_reg   <= '0;
            sw_q_reg   <= '0;
            change_reg <= 1'b0;
            hit_reg    <= 1'b0;
            wrong_reg  <= 1'b0;
            escape_reg <= 1'b0;
            score_reg  <= '0;
            misses_reg <= '0;
        end else begin
            sw_q_reg   <= bus.switches;
            change_reg <= 1'b0;
            hit_reg    <= 1'b0;
            wrong_reg  <= 1'b0;
            escape_reg <= 1'b0;

            if (!bus.enable) begin
                state_reg <= ST_IDLE;
                leds_reg  <= '0;
            end else begin
                case (state_reg)
                    ST_IDLE: begin
                        leds_reg   <= '0;
                        change_reg <= 1'b1;
                        state_reg  <= ST_REQ;
                    end
                    ST_REQ: begin
                        state_reg <= ST_WAIT;
                    end
                    // rng output registers on the change edge, so give it a cycle.
                    ST_WAIT: begin
                        state_reg <= ST_LOAD;
                    end
                    ST_LOAD: begin
                        leds_reg  <= capped;
                        timer_reg <= TW'(UP_TICKS - 1);
                        state_reg <= ST_SHOW;
                    end
                    ST_SHOW: begin
                        score_reg <= sat_add(score_reg, popcount(hits));
                        hit_reg   <= |hits;
                        wrong_reg <= |(rise & ~leds_reg);
                        timer_reg <= timer_reg - TW'(1);
                        if (remain == '0) begin
                            leds_reg  <= '0;
                            timer_reg <= TW'(GAP_TICKS - 1);
                            state_reg <= ST_GAP;
                        end else if (timer_reg == '0) begin
                            misses_reg <= sat_add(misses_reg, popcount(remain));
                            escape_reg <= 1'b1;
                            leds_reg   <= '0;
                            timer_reg  <= TW'(GAP_TICKS - 1);
                            state_reg  <= ST_GAP;
                        end else begin
                            leds_reg <= remain;
                        end
                    end
                    ST_GAP: begin
                        leds_reg <= '0;
                        if (timer_reg == '0) begin
                            change_reg <= 1'b1;
                            state_reg  <= ST_REQ;
                        end else begin
                            timer_reg <= timer_reg - TW'(1);
                        end
                    end
                    default: begin
                        leds_reg  <= '0;
                        state_reg <= ST_IDLE;
                    end
                endcase
            end

            // Clearing overrides any increment from the same cycle.
            if (bus.score_clr) begin
                score_reg  <= '0;
                misses_reg <= '0;
            end
        end
    end

    assign bus.change       = change_reg;
    assign bus.leds         = leds_reg;
    assign bus.hit_pulse    = hit_reg;
    assign bus.wrong_pulse  = wrong_reg;
    assign bus.escape_pulse = escape_reg;
    assign bus.score        = score_reg;
    assign bus.misses       = misses_reg;
endmodule

// File: tb/tb_mole_spawner.sv
// Bench for mole_spawner: round-level model checked every cycle, directed
// scenarios with literal expectations, randomized play and score saturation.
module tb_mole_spawner;
    localparam int N    = 18;
    localparam int MAXM = 3;
    localparam int UP   = 4;
    localparam int GAP  = 2;
    localparam int TW   = 4;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    mole_spawner_if #(.NUM_LEDS(N)) bus ();

    mole_spawner #(
        .NUM_LEDS (N),
        .MAX_MOLES(MAXM),
        .UP_TICKS (UP),
        .GAP_TICKS(GAP),
        .TW       (TW)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.slave)
    );

    int tests = 0;
    int fails = 0;
    bit started = 1'b0;

    // Model state: round progress is tracked as plain countdowns.
    logic [N-1:0] m_leds = '0, m_sw_prev = '0;
    logic         m_change = 0, m_hit = 0, m_wrong = 0, m_esc = 0;
    logic [7:0]   m_score = '0, m_misses = '0;
    int           req_cnt = 0, show_left = 0, gap_left = 0;

    function automatic logic [N-1:0] lowk(input logic [N-1:0] v);
        logic [N-1:0] r, t, lsb;
        r = '0;
        t = v;
        for (int k = 0; k < MAXM; k++) begin
            if (t != '0) begin
                lsb = t & (~t + 1'b1);
                r   = r | lsb;
                t   = t & ~lsb;
            end
        end
        if (r == '0) r = N'(1);
        return r;
    endfunction

    function automatic logic [7:0] sat8(input int s);
        return (s > 255) ? 8'd255 : 8'(s);
    endfunction

    initial begin : model
        logic [N-1:0] rise, hits, remain;
        forever begin
            @(posedge clk);
            rise = bus.switches & ~m_sw_prev;
            m_change = 0; m_hit = 0; m_wrong = 0; m_esc = 0;
            if (!reset) begin
                m_leds = '0; m_sw_prev = '0; m_score = '0; m_misses = '0;
                req_cnt = 0; show_left = 0; gap_left = 0;
            end else begin
                m_sw_prev = bus.switches;
                if (!bus.enable) begin
                    req_cnt = 0; show_left = 0; gap_left = 0; m_leds = '0;
                end else if (req_cnt == 1 || req_cnt == 2) begin
                    req_cnt++;
                end else if (req_cnt == 3) begin
                    req_cnt = 0;
                    m_leds = lowk(bus.random_value);
                    show_left = UP;
                end else if (show_left > 0) begin
                    hits    = rise & m_leds;
                    m_score = sat8(int'(m_score) + $countones(hits));
                    m_hit   = |hits;
                    m_wrong = |(rise & ~m_leds);
                    remain  = m_leds & ~hits;
                    show_left--;
                    if (remain == '0) begin
                        m_leds = '0; show_left = 0; gap_left = GAP;
                    end else if (show_left == 0) begin
                        m_misses = sat8(int'(m_misses) + $countones(remain));
                        m_esc = 1; m_leds = '0; gap_left = GAP;
                    end else begin
                        m_leds = remain;
                    end
                end else if (gap_left > 0) begin
                    gap_left--;
                    if (gap_left == 0) begin
                        req_cnt = 1; m_change = 1;
                    end
                end else begin
                    req_cnt = 1; m_change = 1;
                end
                if (bus.score_clr) begin
                    m_score = '0; m_misses = '0;
                end
            end
            started = 1'b1;
        end
    end

    initial begin : compare
        forever begin
            @(negedge clk);
            if (started) begin
                tests++;
                if ({bus.change, bus.leds, bus.hit_pulse, bus.wrong_pulse, bus.escape_pulse, bus.score, bus.misses}
                    !== {m_change, m_leds, m_hit, m_wrong, m_esc, m_score, m_misses}) begin
                    fails++;
                    $display("FAIL cycle_check t=%0t actual chg=%b leds=%h hit=%b wrong=%b esc=%b score=%0d misses=%0d required chg=%b leds=%h hit=%b wrong=%b esc=%b score=%0d misses=%0d",
                             $time, bus.change, bus.leds, bus.hit_pulse, bus.wrong_pulse, bus.escape_pulse, bus.score, bus.misses,
                             m_change, m_leds, m_hit, m_wrong, m_esc, m_score, m_misses);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end else begin
            $display("[TB] %s ok value=%h", name, act);
        end
    endtask

    task automatic wait_leds();
        int n = 0;
        while (bus.leds == '0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        tests++;
        if (bus.leds == '0) begin
            fails++;
            $display("FAIL wait_leds: actual=timeout required=mask within 60 cycles");
        end
    endtask

    task automatic wait_escape();
        int n = 0;
        while (!bus.escape_pulse && n < 60) begin
            @(negedge clk);
            n++;
        end
        tests++;
        if (!bus.escape_pulse) begin
            fails++;
            $display("FAIL wait_escape: actual=timeout required=escape within 60 cycles");
        end
    endtask

    initial begin : stim
        bus.enable = 0; bus.score_clr = 0; bus.random_value = '0; bus.switches = '0;
        reset = 0;
        repeat (2) @(negedge clk);
        check("model_cap_0F0F0", 32'(lowk(18'h0F0F0)), 32'h00070);
        check("model_cap_zero", 32'(lowk(18'h00000)), 32'h00001);
        check("reset_leds", 32'(bus.leds), 32'h0);
        check("reset_score", 32'(bus.score), 32'h0);

        // Round latency and directed scoring.
        reset = 1; bus.enable = 1; bus.random_value = 18'h0F0F0;
        @(negedge clk); check("change_cycle1", 32'(bus.change), 32'h1);
        @(negedge clk); check("change_cycle2", 32'(bus.change), 32'h0);
        @(negedge clk); check("leds_cycle3", 32'(bus.leds), 32'h0);
        @(negedge clk); check("leds_cycle4", 32'(bus.leds), 32'h00070);
        bus.switches = 18'h00050;
        @(negedge clk);
        check("hit_pulse", 32'(bus.hit_pulse), 32'h1);
        check("score_after_hit", 32'(bus.score), 32'd2);
        check("leds_after_hit", 32'(bus.leds), 32'h00020);
        bus.switches = 18'h00051;
        @(negedge clk);
        check("wrong_pulse", 32'(bus.wrong_pulse), 32'h1);
        check("score_after_wrong", 32'(bus.score), 32'd2);
        @(negedge clk); check("no_escape_yet", 32'(bus.escape_pulse), 32'h0);
        @(negedge clk);
        check("escape_pulse", 32'(bus.escape_pulse), 32'h1);
        check("misses_1", 32'(bus.misses), 32'd1);
        check("leds_gap", 32'(bus.leds), 32'h0);
        bus.switches = '0;
        wait_leds();
        check("leds_round2", 32'(bus.leds), 32'h00070);
        wait_escape();
        check("misses_4", 32'(bus.misses), 32'd4);

        // Randomized play.
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            bus.random_value = N'($urandom & $urandom & $urandom);
            case ($urandom_range(3, 0))
                0: bus.switches = '0;
                1: bus.switches = bus.switches | (18'd1 << $urandom_range(N - 1, 0));
                2: bus.switches = bus.switches | (bus.leds & N'($urandom));
                default: ;
            endcase
            bus.enable    = ($urandom_range(39, 0) != 0);
            bus.score_clr = ($urandom_range(99, 0) == 0);
            reset         = ($urandom_range(299, 0) != 0);
        end

        // Score saturation and clear priority.
        @(negedge clk);
        reset = 1; bus.enable = 0; bus.score_clr = 1; bus.switches = '0;
        bus.random_value = 18'h00007;
        @(negedge clk);
        bus.score_clr = 0; bus.enable = 1;
        for (int r = 0; r < 84; r++) begin
            wait_leds();
            bus.switches = 18'h00007;
            @(negedge clk);
            bus.switches = '0;
        end
        check("score_252", 32'(bus.score), 32'd252);
        wait_leds();
        bus.switches = 18'h00003;
        @(negedge clk);
        check("score_254", 32'(bus.score), 32'd254);
        wait_escape();
        check("misses_sat_phase", 32'(bus.misses), 32'd1);
        bus.switches = '0;
        wait_leds();
        bus.switches = 18'h00003;
        @(negedge clk);
        check("score_sat_255", 32'(bus.score), 32'd255);
        bus.switches = 18'h00007; bus.score_clr = 1;
        @(negedge clk);
        check("clear_wins_score", 32'(bus.score), 32'd0);
        check("clear_wins_misses", 32'(bus.misses), 32'd0);
        bus.score_clr = 0; bus.switches = '0;
        repeat (5) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
